// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: oversamples BCLK/LRCLK/ADCDAT in the clk domain,
// captures DATA_SIZE MSB-first bits per slot and presents left/right pairs.
module i2s_rx_deserializer #(
  parameter int unsigned DATA_SIZE   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic                 adcdat,
  output logic [DATA_SIZE-1:0] out_left,
  output logic [DATA_SIZE-1:0] out_right,
  output logic                 out_ready,
  output logic                 frame_err,
  output logic [7:0]           err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    PAD    = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, dat_sync;
  logic                   bclk_s, lr_s, dat_s;
  logic                   bclk_d;
  logic                   lr_prev;
  logic                   sample_evt, boundary;

  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_SIZE-1:0]   shift_q;
  logic [DATA_SIZE-1:0]   left_hold;
  logic                   left_valid;
  logic                   chan_q;

  logic                   shift_en, slot_start, commit, short_slot;

  // Equal-depth synchronizers keep the three codec lines mutually aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
      bclk_d    <= bclk_s;
    end
  end

  assign bclk_s     = bclk_sync[SYNC_STAGES-1];
  assign lr_s       = lr_sync[SYNC_STAGES-1];
  assign dat_s      = dat_sync[SYNC_STAGES-1];
  assign sample_evt = bclk_s & ~bclk_d;
  assign boundary   = sample_evt & (lr_s != lr_prev);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_nxt;
  end

  // Next-state and datapath control; the boundary bit itself is never shifted
  always_comb begin
    state_nxt  = state_q;
    shift_en   = 1'b0;
    slot_start = 1'b0;
    commit     = 1'b0;
    short_slot = 1'b0;
    case (state_q)
      HUNT: begin
        if (boundary && !lr_s) begin
          state_nxt  = SHIFT;
          slot_start = 1'b1;
        end
      end
      SHIFT: begin
        if (boundary) begin
          short_slot = 1'b1;
          slot_start = 1'b1;
        end else if (sample_evt) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(DATA_SIZE - 1)) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = PAD;
      end
      PAD: begin
        if (boundary) begin
          state_nxt  = SHIFT;
          slot_start = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Shift register, slot bookkeeping, pairing and error counting
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_prev    <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      left_hold  <= '0;
      left_valid <= 1'b0;
      chan_q     <= 1'b0;
      out_left   <= '0;
      out_right  <= '0;
      out_ready  <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      out_ready <= 1'b0;
      frame_err <= 1'b0;
      if (sample_evt) lr_prev <= lr_s;
      if (slot_start) begin
        cnt_q  <= '0;
        chan_q <= lr_s;
      end
      if (shift_en) begin
        shift_q <= {shift_q[DATA_SIZE-2:0], dat_s};
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (short_slot) begin
        frame_err  <= 1'b1;
        left_valid <= 1'b0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (commit) begin
        if (!chan_q) begin
          left_hold  <= shift_q;
          left_valid <= 1'b1;
        end else if (left_valid) begin
          out_left   <= left_hold;
          out_right  <= shift_q;
          out_ready  <= 1'b1;
          left_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Self-checking bench for i2s_rx_deserializer: table-driven frames with a
// scoreboard of expected stereo pairs, plus reset and error-saturation sequences.
module tb_i2s_rx_deserializer;

  localparam int unsigned DS   = 24;
  localparam int unsigned SYNC = 2;
  localparam int          HALF = 8;   // 16 clk per BCLK -> 3.125 MHz

  logic          clk = 1'b0;
  logic          rst;
  logic          bclk, lrclk, adcdat;
  logic [DS-1:0] out_left, out_right;
  logic          out_ready, frame_err;
  logic [7:0]    err_count;

  i2s_rx_deserializer #(.DATA_SIZE(DS), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .adcdat    (adcdat),
    .out_left  (out_left),
    .out_right (out_right),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [DS-1:0] left;
    logic [DS-1:0] right;
  } pair_t;

  typedef struct {
    logic [DS-1:0] left;
    logic [DS-1:0] right;
    int            nl;        // data bits sent in the left slot
    int            npad;      // padding bits (value 1) after data in each slot
    bit            strobe;    // a pair is expected from this frame
    logic [7:0]    err_exp;   // err_count expected after the frame
  } vec_t;

  pair_t      sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         err_pulses = 0;
  logic [DS-1:0] prev_l = '0;
  logic [DS-1:0] prev_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clk and run the per-cycle output monitor
  task automatic tick();
    pair_t e;
    @(negedge clk);
    if (out_ready) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_strobe: got L=0x%0h R=0x%0h, expected no out_ready", out_left, out_right);
      end else begin
        e = sb.pop_front();
        check("strobe_left", 32'(out_left), 32'(e.left));
        check("strobe_right", 32'(out_right), 32'(e.right));
      end
    end else if (!rst) begin
      n_assert++;
      if (out_left !== prev_l || out_right !== prev_r) begin
        n_fail++;
        $display("FAIL output_hold: got L=0x%0h R=0x%0h, expected L=0x%0h R=0x%0h",
                 out_left, out_right, prev_l, prev_r);
      end
    end
    prev_l = out_left;
    prev_r = out_right;
    if (frame_err) err_pulses++;
  endtask

  // One BCLK period: data/lrclk change while BCLK is low, sampled on the rise
  task automatic send_bit(input logic lr, input logic d, input int half);
    lrclk  = lr;
    adcdat = d;
    repeat (half) tick();
    bclk = 1'b1;
    repeat (half) tick();
    bclk = 1'b0;
  endtask

  // Slot = one delay bit (previous slot's tail) + nbits MSB-first + npad ones
  task automatic send_slot(input logic lr, input logic [DS-1:0] w, input int nbits,
                           input int npad, input int half);
    send_bit(lr, 1'b1, half);
    for (int i = 0; i < nbits; i++) send_bit(lr, w[DS-1-i], half);
    for (int i = 0; i < npad; i++) send_bit(lr, 1'b1, half);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{24'hABCDEF, 24'h123456, 24, 7, 1'b1, 8'd0};
    vecs[1] = '{24'hABCDEF, 24'h123456, 24, 7, 1'b1, 8'd0};
    vecs[2] = '{24'h000001, 24'h800000, 24, 0, 1'b1, 8'd0};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 24, 0, 1'b1, 8'd0};
    vecs[4] = '{24'h555555, 24'hAAAAAA, 24, 0, 1'b1, 8'd0};
    vecs[5] = '{24'hABCDEF, 24'h123456, 20, 0, 1'b0, 8'd1};
    vecs[6] = '{24'h0F0F0F, 24'hF0F0F0, 24, 7, 1'b1, 8'd1};
    vecs[7] = '{24'h13579B, 24'h2468AC, 24, 7, 1'b1, 8'd1};

    rst = 1'b1; bclk = 1'b0; lrclk = 1'b1; adcdat = 1'b0;
    repeat (5) tick();
    check("reset_out_left", 32'(out_left), 32'h0);
    check("reset_out_right", 32'(out_right), 32'h0);
    check("reset_out_ready", 32'(out_ready), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_err_count", 32'(err_count), 32'h0);
    rst = 1'b0;
    tick();

    // Start in the middle of a right slot: must not produce a pair
    send_slot(1'b1, 24'h777777, 10, 0, HALF);
    check("midslot_no_strobe", 32'(sb.size()), 32'd0);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].strobe) sb.push_back('{left: vecs[v].left, right: vecs[v].right});
      send_slot(1'b0, vecs[v].left, vecs[v].nl, vecs[v].npad, HALF);
      send_slot(1'b1, vecs[v].right, 24, vecs[v].npad, HALF);
      check($sformatf("frame%0d_pending", v), 32'(sb.size()), 32'd0);
      check($sformatf("frame%0d_err_count", v), 32'(err_count), 32'(vecs[v].err_exp));
    end
    check("frame_err_pulses", 32'(err_pulses), 32'd1);

    // Reset after 12 right-channel bits: slot abandoned, outputs cleared
    send_slot(1'b0, 24'hC0FFEE, 24, 7, HALF);
    send_bit(1'b1, 1'b1, HALF);
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0, HALF);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midreset_out_left", 32'(out_left), 32'h0);
    check("midreset_out_right", 32'(out_right), 32'h0);
    check("midreset_out_ready", 32'(out_ready), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    check("midreset_err_count", 32'(err_count), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1, HALF);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1, HALF);
    check("midreset_no_strobe", 32'(sb.size()), 32'd0);
    sb.push_back('{left: 24'h5A5A5A, right: 24'hC3C3C3});
    send_slot(1'b0, 24'h5A5A5A, 24, 7, HALF);
    send_slot(1'b1, 24'hC3C3C3, 24, 7, HALF);
    check("postreset_pending", 32'(sb.size()), 32'd0);
    check("postreset_err_count", 32'(err_count), 32'd0);

    // 301 four-bit slots: first starts a left slot, the next 300 are short
    err_pulses = 0;
    for (int k = 0; k <= 300; k++) begin
      send_slot(1'(k % 2), 24'h0, 3, 0, 4);
      if (k == 100) check("short_count_100", 32'(err_count), 32'd100);
      if (k == 255) check("short_count_255", 32'(err_count), 32'd255);
    end
    repeat (10) tick();
    check("err_count_saturated", 32'(err_count), 32'd255);
    check("short_pulses", 32'(err_pulses), 32'd300);
    check("final_pending", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
